// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, sequencer state type and bit-reverse helper
package fft_pkg;

  localparam int NFFT_DEF  = 512;
  localparam int LOG2N_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_WB,
    ST_DONE
  } seq_state_e;

  // Reverses the low log2n bits of idx; the frame loader uses it for its write addresses.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int log2n);
    logic [15:0] r;
    logic [15:0] v;
    r = '0;
    v = idx;
    for (int i = 0; i < 16; i++) begin
      if (i < log2n) begin
        r = {r[14:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_sequencer_if.sv
// rtl/fft_bfly_sequencer_if.sv - butterfly request and write-back channel
interface fft_bfly_sequencer_if import fft_pkg::*; #(
  parameter int NFFT = NFFT_DEF
) ();
  localparam int LOG2N = $clog2(NFFT);
  localparam int TW_W  = $clog2(NFFT / 2);
  localparam int STG_W = $clog2(LOG2N + 1);

  logic             bfly_valid_o;
  logic             bfly_ready_i;
  logic [LOG2N-1:0] addr_a_o;
  logic [LOG2N-1:0] addr_b_o;
  logic [TW_W-1:0]  tw_idx_o;
  logic [STG_W-1:0] stage_o;
  logic             wb_i;

  modport master (
    output bfly_valid_o, addr_a_o, addr_b_o, tw_idx_o, stage_o,
    input  bfly_ready_i, wb_i
  );

  modport slave (
    input  bfly_valid_o, addr_a_o, addr_b_o, tw_idx_o, stage_o,
    output bfly_ready_i, wb_i
  );
endinterface

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - maps (stage, butterfly index) to operand addresses and twiddle index
module fft_addr_gen import fft_pkg::*; #(
  parameter  int NFFT  = NFFT_DEF,
  localparam int LOG2N = $clog2(NFFT),
  localparam int TW_W  = $clog2(NFFT / 2),
  localparam int STG_W = $clog2(LOG2N + 1)
) (
  input  logic [STG_W-1:0] stage_i,
  input  logic [TW_W-1:0]  k_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [TW_W-1:0]  tw_idx_o
);
  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;

  // Low s bits of k pick the position inside a group; the rest pick the group.
  always_comb begin
    k_ext    = {1'b0, k_i};
    half     = LOG2N'(1) << stage_i;
    pos      = k_ext & (half - LOG2N'(1));
    grp      = k_ext >> stage_i;
    addr_a_o = (grp << (stage_i + STG_W'(1))) | pos;
    addr_b_o = addr_a_o + half;
    tw_idx_o = TW_W'(pos << (LOG2N - 1 - int'(stage_i)));
  end
endmodule

// File: rtl/fft_bfly_sequencer.sv
// rtl/fft_bfly_sequencer.sv - radix-2 DIT FFT butterfly issue sequencer
// Issues NFFT/2 butterflies per stage and holds each stage until all its write-backs land.
module fft_bfly_sequencer import fft_pkg::*; #(
  parameter  int NFFT  = NFFT_DEF,
  localparam int LOG2N = $clog2(NFFT),
  localparam int TW_W  = $clog2(NFFT / 2),
  localparam int STG_W = $clog2(LOG2N + 1),
  localparam int CNT_W = $clog2(NFFT / 2 + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  fft_bfly_sequencer_if.master        bfly
);
  localparam int                 HALF     = NFFT / 2;
  localparam logic [TW_W-1:0]    K_LAST   = TW_W'(HALF - 1);
  localparam logic [STG_W-1:0]   S_LAST   = STG_W'(LOG2N - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(HALF);

  seq_state_e       state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [TW_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [LOG2N-1:0] addr_a_q, addr_b_q, gen_a, gen_b;
  logic [TW_W-1:0]  tw_q, gen_tw;
  logic             xfer, wb_active, wb_ok, stage_full;

  assign xfer       = valid_q & bfly.bfly_ready_i;
  assign wb_active  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_WB);
  assign wb_ok      = bfly.wb_i & wb_active & (wb_cnt_q != CNT_FULL);
  assign stage_full = (wb_cnt_q + CNT_W'(wb_ok)) == CNT_FULL;

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    k_d      = k_q;
    wb_cnt_d = wb_cnt_q + CNT_W'(wb_ok);
    err_d    = err_q | (bfly.wb_i & ~wb_ok);
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_ISSUE;
          stage_d  = '0;
          k_d      = '0;
          wb_cnt_d = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          valid_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          if (k_q == K_LAST) begin
            state_d = ST_WAIT_WB;
            valid_d = 1'b0;
          end else begin
            k_d = k_q + TW_W'(1);
          end
        end
      end
      ST_WAIT_WB: begin
        // The counter may complete on this cycle's own write-back.
        if (stage_full) begin
          if (stage_q == S_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            stage_d  = stage_q + STG_W'(1);
            k_d      = '0;
            wb_cnt_d = '0;
            valid_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  fft_addr_gen #(.NFFT(NFFT)) u_addr_gen (
    .stage_i  (stage_d),
    .k_i      (k_d),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      wb_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      k_q      <= k_d;
      wb_cnt_q <= wb_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      // Addresses are zero whenever no request is being presented.
      addr_a_q <= valid_d ? gen_a  : '0;
      addr_b_q <= valid_d ? gen_b  : '0;
      tw_q     <= valid_d ? gen_tw : '0;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign bfly.bfly_valid_o = valid_q;
  assign bfly.addr_a_o     = addr_a_q;
  assign bfly.addr_b_o     = addr_b_q;
  assign bfly.tw_idx_o     = tw_q;
  assign bfly.stage_o      = stage_q;
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// tb/tb_fft_bfly_sequencer.sv - directed bench for the FFT butterfly sequencer
module tb_fft_bfly_sequencer;
  import fft_pkg::*;

  localparam int N8   = 8;
  localparam int N512 = NFFT_DEF;

  logic clk = 1'b0;
  logic rst_n;
  logic start8, start512;
  logic busy8, done8, err8, busy512, done512, err512;
  logic ready8, ready512, wb_man8, wb512;
  logic wb_echo8 = 1'b0;
  logic echo_en8 = 1'b0;
  logic [1:0] pipe8 = 2'b00;

  int n_chk = 0;
  int n_fail = 0;
  int t, cyc, exp_s, exp_k, xfers, dones, wb_sent, wb_prev, last_due, d;
  int due_q[$];
  logic prev_stall;
  logic [31:0] vec512, prev_vec;

  int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_bfly_sequencer_if #(.NFFT(N8))   bus8 ();
  fft_bfly_sequencer_if #(.NFFT(N512)) bus512 ();

  assign bus8.bfly_ready_i   = ready8;
  assign bus8.wb_i           = wb_echo8 | wb_man8;
  assign bus512.bfly_ready_i = ready512;
  assign bus512.wb_i         = wb512;

  fft_bfly_sequencer #(.NFFT(N8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .busy_o(busy8),
    .done_o(done8), .err_o(err8), .bfly(bus8.master)
  );

  fft_bfly_sequencer #(.NFFT(N512)) u512 (
    .clk(clk), .rst_n(rst_n), .start_i(start512), .busy_o(busy512),
    .done_o(done512), .err_o(err512), .bfly(bus512.master)
  );

  always #5 clk = ~clk;

  // Write-back echo: every accepted request returns two cycles later.
  always @(negedge clk) begin
    if (!echo_en8) begin
      pipe8    <= 2'b00;
      wb_echo8 <= 1'b0;
    end else begin
      wb_echo8 <= pipe8[1];
      pipe8    <= {pipe8[0], bus8.bfly_valid_o & ready8};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_req8(input string tag, input int a, input int b, input int tw, input int s);
    chk({tag, "_valid"}, 32'(bus8.bfly_valid_o), 32'd1);
    chk({tag, "_a"},     32'(bus8.addr_a_o),     32'(a));
    chk({tag, "_b"},     32'(bus8.addr_b_o),     32'(b));
    chk({tag, "_tw"},    32'(bus8.tw_idx_o),     32'(tw));
    chk({tag, "_stage"}, 32'(bus8.stage_o),      32'(s));
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_valid"}, 32'(bus8.bfly_valid_o), 32'd0);
    chk({tag, "_busy"},  32'(busy8),             32'd0);
    chk({tag, "_done"},  32'(done8),             32'd0);
    chk({tag, "_err"},   32'(err8),              32'd0);
    chk({tag, "_a"},     32'(bus8.addr_a_o),     32'd0);
    chk({tag, "_b"},     32'(bus8.addr_b_o),     32'd0);
    chk({tag, "_tw"},    32'(bus8.tw_idx_o),     32'd0);
    chk({tag, "_stage"}, 32'(bus8.stage_o),      32'd0);
  endtask

  function automatic logic [31:0] exp_vec(input int s, input int k);
    int half, pos, grp, a;
    half = 1 << s;
    pos  = k % half;
    grp  = k / half;
    a    = grp * 2 * half + pos;
    return {2'b00, 9'(a), 9'(a + half), 8'(pos * (256 / half)), 4'(s)};
  endfunction

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start512 = 1'b0;
    ready8 = 1'b1; ready512 = 1'b0; wb_man8 = 1'b0; wb512 = 1'b0;
    nclk(2);
    chk_zero8("reset");
    chk("reset_busy512", 32'(busy512), 32'd0);
    rst_n = 1'b1;
    nclk(2);

    // NFFT=8 full transform, write-backs echoed two cycles after issue
    echo_en8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("t1_busy_first", 32'(busy8), 32'd1);
    for (int i = 0; i < 12; i++) begin
      t = 0;
      while (bus8.bfly_valid_o !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk_req8($sformatf("t1_req%0d", i), exp_a[i], exp_b[i], exp_tw[i], i / 4);
      @(negedge clk);
    end
    t = 0;
    while (done8 !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("t1_done", 32'(done8), 32'd1);
    chk("t1_done_busy", 32'(busy8), 32'd0);
    chk("t1_done_err", 32'(err8), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done8), 32'd0);
    chk("t1_idle_busy", 32'(busy8), 32'd0);

    // Unexpected write-back while idle
    echo_en8 = 1'b0;
    wb_man8 = 1'b1;
    @(negedge clk);
    wb_man8 = 1'b0;
    chk("t2_err_idle", 32'(err8), 32'd1);
    nclk(3);
    chk("t2_err_sticky", 32'(err8), 32'd1);

    // Start clears err; stage 0 waits for write-backs indefinitely
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("t3_err_clr", 32'(err8), 32'd0);
    chk_req8("t3_first", 0, 1, 0, 0);
    nclk(4);
    chk("t3_wait_valid", 32'(bus8.bfly_valid_o), 32'd0);
    nclk(10);
    chk("t3_hold_valid", 32'(bus8.bfly_valid_o), 32'd0);
    chk("t3_hold_stage", 32'(bus8.stage_o), 32'd0);
    chk("t3_hold_busy", 32'(busy8), 32'd1);
    wb_man8 = 1'b1;
    nclk(4);
    wb_man8 = 1'b0;
    chk_req8("t3_stage1", 0, 2, 0, 1);

    // start_i mid-stage is ignored
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk_req8("t4_next", 1, 3, 2, 1);
    chk("t4_busy", 32'(busy8), 32'd1);
    chk("t4_err", 32'(err8), 32'd0);

    // Stall with a fifth write-back in the same stage
    ready8 = 1'b0;
    wb_man8 = 1'b1;
    nclk(5);
    wb_man8 = 1'b0;
    chk("t5_err_extra", 32'(err8), 32'd1);
    chk_req8("t5_stall", 1, 3, 2, 1);
    nclk(2);
    chk("t5_err_sticky", 32'(err8), 32'd1);
    chk_req8("t5_stall_late", 1, 3, 2, 1);

    // Asynchronous reset mid-stage, then a clean restart
    #2 rst_n = 1'b0;
    #1 chk_zero8("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    ready8 = 1'b1;
    echo_en8 = 1'b1;
    nclk(1);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk_req8("t6_restart0", 0, 1, 0, 0);
    @(negedge clk);
    chk_req8("t6_restart1", 2, 3, 0, 0);
    t = 0;
    while (done8 !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("t6_done", 32'(done8), 32'd1);
    chk("t6_done_err", 32'(err8), 32'd0);
    echo_en8 = 1'b0;

    // NFFT=512 with random ready and random write-back delay
    start512 = 1'b1;
    @(negedge clk);
    start512 = 1'b0;
    cyc = 0; exp_s = 0; exp_k = 0; xfers = 0; dones = 0; wb_sent = 0; last_due = 0;
    prev_stall = 1'b0;
    prev_vec = '0;
    while (cyc < 20000 && dones == 0) begin
      vec512  = {2'b00, bus512.addr_a_o, bus512.addr_b_o, bus512.tw_idx_o, bus512.stage_o};
      wb_prev = wb_sent;
      if (done512 === 1'b1) dones++;
      if (prev_stall) chk("t7_stall_hold", vec512, prev_vec);
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        wb512 = 1'b1;
        wb_sent++;
      end else begin
        wb512 = 1'b0;
      end
      ready512 = 1'($urandom_range(0, 1));
      if (bus512.bfly_valid_o === 1'b1 && ready512) begin
        if (exp_k == 0 && exp_s > 0) chk("t7_stage_gate", 32'(wb_prev), 32'(256 * exp_s));
        chk("t7_issue", vec512, exp_vec(exp_s, exp_k));
        xfers++;
        d = cyc + int'($urandom_range(1, 5));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        due_q.push_back(d);
        exp_k++;
        if (exp_k == 256) begin
          exp_k = 0;
          exp_s++;
        end
      end
      prev_stall = (bus512.bfly_valid_o === 1'b1) && !ready512;
      prev_vec   = vec512;
      @(negedge clk);
      cyc++;
    end
    wb512 = 1'b0;
    ready512 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done512 === 1'b1) dones++;
    end
    chk("t7_xfers", 32'(xfers), 32'd2304);
    chk("t7_wbs", 32'(wb_sent), 32'd2304);
    chk("t7_done_once", 32'(dones), 32'd1);
    chk("t7_err", 32'(err512), 32'd0);
    chk("t7_busy_end", 32'(busy512), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
